pc_fetch_unit: RTL and testbench

//  Owns the program counter and instruction fetch. Loads newPC from the next-PC mux on pc_write, then

---
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit, ack/data back from memory.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch FSM (IDLE/REQ/DONE/ERR) with request timeout.
// Optional PC range check enabled by defining PC_LIMIT_EN.
module pc_fetch_unit #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15,
  parameter int PC_LIMIT = 63
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_start,
  input  logic              pc_write,
  input  logic              stall,
  input  logic [ADDR_W-1:0] newPC,
  pc_fetch_unit_if.master   imem,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fetch_err,
  output logic              pc_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W:0]   LIMIT_V  = (ADDR_W + 1)'(PC_LIMIT);
`ifdef PC_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              req_q;
  logic              err_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pc_over_s;

  assign pc_over_s = LIMIT_EN && ({1'b0, newPC} > LIMIT_V);

  // Fetch FSM; every output is a register so the async reset clears them without a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      instr_q <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_start) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
          end
        end
        S_REQ: begin
          // Ack is tested first so a same-cycle ack beats the timeout.
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (pc_write && !stall) begin
            valid_q <= 1'b0;
            if (pc_over_s) begin
              fault_q <= 1'b1;
              state_q <= S_ERR;
            end else begin
              pc_q    <= newPC;
              req_q   <= 1'b1;
              cnt_q   <= {CNT_W{1'b0}};
              state_q <= S_REQ;
            end
          end
        end
        S_ERR: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_ERR;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus1       = pc_q + 1'b1;
  assign fetch_err      = err_q;
  assign pc_fault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; define PC_LIMIT_EN to exercise the range check.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

`ifdef PC_LIMIT_EN
  localparam int LIMIT = 31;
`else
  localparam int LIMIT = 63;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_write = 1'b0;
  logic        stall = 1'b0;
  logic [5:0]  newPC = 6'd0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [5:0]  pc;
  logic [5:0]  pc_plus1;
  logic        fetch_err;
  logic        pc_fault;
  int          n_checks = 0;
  int          n_errors = 0;

  pc_fetch_unit_if #(.ADDR_W(6), .DATA_W(16)) imem_bus ();

  pc_fetch_unit #(
    .ADDR_W(6), .DATA_W(16), .RESET_PC(0), .TIMEOUT(15), .PC_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .fetch_start(fetch_start),
    .pc_write(pc_write), .stall(stall), .newPC(newPC), .imem(imem_bus.master),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus1(pc_plus1),
    .fetch_err(fetch_err), .pc_fault(pc_fault)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    #2;
    check_eq("rst_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("rst_pc",    {26'd0, pc}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", {16'd0, instr}, 32'd0);
    check_eq("rst_err",   {31'd0, fetch_err}, 32'd0);
    check_eq("rst_fault", {31'd0, pc_fault}, 32'd0);
    step();
    reset_n = 1'b1;
    // pc_write in IDLE is ignored
    pc_write = 1'b1; newPC = 6'd20;
    step();
    check_eq("idle_pcw_pc", {26'd0, pc}, 32'd0);
    check_eq("idle_req",    {31'd0, imem_bus.imem_req}, 32'd0);
    pc_write = 1'b0;

    // first fetch, acked in the first REQ cycle
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("f1_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    check_eq("f1_addr",  {26'd0, imem_bus.imem_addr}, 32'd0);
    check_eq("f1_plus1", {26'd0, pc_plus1}, 32'd1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'hA5C3;
    step();
    imem_bus.imem_ack = 1'b0;
    check_eq("f1_instr", {16'd0, instr}, 32'h0000A5C3);
    check_eq("f1_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("f1_req0",  {31'd0, imem_bus.imem_req}, 32'd0);

    // ack while in DONE must not touch instr
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'hFFFF;
    step();
    imem_bus.imem_ack = 1'b0;
    check_eq("done_ack_ign", {16'd0, instr}, 32'h0000A5C3);

    // jump to 40, ack after three wait cycles
    newPC = 6'd40; pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("j40_valid0", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("j40_req",  {31'd0, imem_bus.imem_req}, 32'd1);
      check_eq("j40_addr", {26'd0, imem_bus.imem_addr}, 32'd40);
      if (i == 3) begin
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h1234;
      end
      step();
    end
    imem_bus.imem_ack = 1'b0;
    check_eq("j40_reqoff", {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("j40_instr",  {16'd0, instr}, 32'h00001234);
    check_eq("j40_valid",  {31'd0, instr_valid}, 32'd1);

    // stalled pc_write has no effect until stall drops
    newPC = 6'd9; pc_write = 1'b1; stall = 1'b1;
    step();
    check_eq("stall_pc",    {26'd0, pc}, 32'd40);
    check_eq("stall_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
    stall = 1'b0;
    step();
    pc_write = 1'b0;
    check_eq("unstall_pc",  {26'd0, pc}, 32'd9);
    check_eq("unstall_req", {31'd0, imem_bus.imem_req}, 32'd1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'hBEEF;
    step();
    imem_bus.imem_ack = 1'b0;
    check_eq("f9_instr", {16'd0, instr}, 32'h0000BEEF);

    // fetch_start outside IDLE is ignored
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("done_fs_req", {31'd0, imem_bus.imem_req}, 32'd0);

    // load 63, then time out
    newPC = 6'd63; pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("p63_pc",    {26'd0, pc}, 32'd63);
    check_eq("p63_plus1", {26'd0, pc_plus1}, 32'd0);
    for (int i = 0; i < 14; i++) step();
    check_eq("to_req14", {31'd0, imem_bus.imem_req}, 32'd1);
    check_eq("to_err14", {31'd0, fetch_err}, 32'd0);
    step();
    check_eq("to_err",   {31'd0, fetch_err}, 32'd1);
    check_eq("to_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("to_valid", {31'd0, instr_valid}, 32'd0);
    // ERR is sticky against every input
    imem_bus.imem_ack = 1'b1; fetch_start = 1'b1; pc_write = 1'b1; newPC = 6'd5;
    step();
    step();
    imem_bus.imem_ack = 1'b0; fetch_start = 1'b0; pc_write = 1'b0;
    check_eq("err_req",  {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("err_pc",   {26'd0, pc}, 32'd63);
    check_eq("err_stky", {31'd0, fetch_err}, 32'd1);

    // async reset out of ERR, mid-cycle
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar_err", {31'd0, fetch_err}, 32'd0);
    check_eq("ar_pc",  {26'd0, pc}, 32'd0);
    step();
    reset_n = 1'b1;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("ar2_req1", {31'd0, imem_bus.imem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar2_req0",  {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("ar2_valid", {31'd0, instr_valid}, 32'd0);
    step();
    reset_n = 1'b1;

    // range check around the PC limit
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h0F0F;
    step();
    imem_bus.imem_ack = 1'b0;
    newPC = 6'd32; pc_write = 1'b1;
    step();
    pc_write = 1'b0;
`ifdef PC_LIMIT_EN
    check_eq("lim32_fault", {31'd0, pc_fault}, 32'd1);
    check_eq("lim32_pc",    {26'd0, pc}, 32'd0);
    check_eq("lim32_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("lim32_valid", {31'd0, instr_valid}, 32'd0);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    imem_bus.imem_ack = 1'b1;
    step();
    imem_bus.imem_ack = 1'b0;
    newPC = 6'd31; pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("lim31_pc",    {26'd0, pc}, 32'd31);
    check_eq("lim31_fault", {31'd0, pc_fault}, 32'd0);
    check_eq("lim31_req",   {31'd0, imem_bus.imem_req}, 32'd1);
`else
    check_eq("nolim_pc",    {26'd0, pc}, 32'd32);
    check_eq("nolim_fault", {31'd0, pc_fault}, 32'd0);
    check_eq("nolim_req",   {31'd0, imem_bus.imem_req}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
